// File: rtl/icache_line_fill_if.sv
// Handshake bundle between the instruction-line fill engine, the core fetch port
// and the 64-bit memory port. The engine connects through the master modport.
interface icache_line_fill_if #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  logic [63:0]              icache_req_addr;
  logic                     icache_req_addr_valid;
  logic                     icache_req_addr_retry;

  logic [BEAT_W*BEATS-1:0]  icache_ack_data;
  logic                     icache_ack_data_valid;
  logic                     icache_ack_data_retry;

  logic [63:0]              mem_req_addr;
  logic                     mem_req_valid;
  logic                     mem_req_retry;

  logic [BEAT_W-1:0]        mem_ack_data;
  logic                     mem_ack_valid;
  logic                     mem_ack_retry;

  modport master (
    input  icache_req_addr, icache_req_addr_valid,
    output icache_req_addr_retry,
    output icache_ack_data, icache_ack_data_valid,
    input  icache_ack_data_retry,
    output mem_req_addr, mem_req_valid,
    input  mem_req_retry,
    input  mem_ack_data, mem_ack_valid,
    output mem_ack_retry
  );

  modport slave (
    output icache_req_addr, icache_req_addr_valid,
    input  icache_req_addr_retry,
    input  icache_ack_data, icache_ack_data_valid,
    output icache_ack_data_retry,
    input  mem_req_addr, mem_req_valid,
    output mem_req_retry,
    output mem_ack_data, mem_ack_valid,
    input  mem_ack_retry
  );
endinterface

// File: rtl/icache_line_fill.sv
// Single-outstanding instruction-line fill: one core line request becomes one
// burst read whose BEATS returned beats are packed into a line for the core.
module icache_line_fill #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  icache_line_fill_if.master bus
);

  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [63:0]      LINE_MASK = ~64'(BEAT_W * BEATS / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, RESP} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             beat_q;
  logic [63:0]                  line_addr_q;
  logic [BEATS-1:0][BEAT_W-1:0] line_q;

  logic req_fire;
  logic mem_req_fire;
  logic beat_fire;
  logic resp_fire;

  // Transfers are qualified by the current state only, so a beat or request
  // seen in the wrong state can never touch the datapath.
  assign req_fire     = (state_q == IDLE) && bus.icache_req_addr_valid;
  assign mem_req_fire = (state_q == REQ)  && !bus.mem_req_retry;
  assign beat_fire    = (state_q == RECV) && bus.mem_ack_valid;
  assign resp_fire    = (state_q == RESP) && !bus.icache_ack_data_retry;

  always_comb begin
    state_d                   = state_q;
    bus.icache_req_addr_retry = 1'b1;
    bus.icache_ack_data_valid = 1'b0;
    bus.mem_req_valid         = 1'b0;
    bus.mem_ack_retry         = 1'b1;
    case (state_q)
      IDLE: begin
        bus.icache_req_addr_retry = 1'b0;
        if (req_fire) state_d = REQ;
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (mem_req_fire) state_d = RECV;
      end
      RECV: begin
        bus.mem_ack_retry = 1'b0;
        if (beat_fire && (beat_q == LAST_BEAT)) state_d = RESP;
      end
      RESP: begin
        bus.icache_ack_data_valid = 1'b1;
        if (resp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and line are straight register views; no input feeds an output.
  assign bus.mem_req_addr    = line_addr_q;
  assign bus.icache_ack_data = line_q;

  // State, beat counter and line buffer all clear on reset so an aborted fill
  // leaves nothing behind on the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_addr_q <= '0;
      line_q      <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) line_addr_q <= bus.icache_req_addr & LINE_MASK;
      if (mem_req_fire) beat_q <= '0;
      else if (beat_fire) beat_q <= beat_q + CNT_W'(1);
      if (beat_fire) line_q[beat_q] <= bus.mem_ack_data;
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: a table of fill scenarios plus
// hand-written reset sequences.
module tb_icache_line_fill;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  icache_line_fill_if #(.BEAT_W(64), .BEATS(4)) bus ();

  icache_line_fill #(.BEAT_W(64), .BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp_addr;
    logic [63:0] b0, b1, b2, b3;
    int          req_retry;
    int          gap;
    int          core_retry;
    bit          spur;
    bit          chain;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_retry"}, bus.icache_req_addr_retry, 0);
    chk({tag, "_ack_valid"}, bus.icache_ack_data_valid, 0);
    chk({tag, "_ack_data"},  bus.icache_ack_data,       0);
    chk({tag, "_mem_valid"}, bus.mem_req_valid,         0);
    chk({tag, "_mem_addr"},  bus.mem_req_addr,          0);
    chk({tag, "_ack_retry"}, bus.mem_ack_retry,         1);
  endtask

  // Runs one complete fill starting at a negedge with the engine in IDLE.
  task automatic do_fill(input int i);
    vec_t          v;
    logic [63:0]   bt [4];
    logic [255:0]  exp_line;
    bit            hold_ok, busy_ok, early_ok, spur_ok, ackr_ok, line_ok;
    int            cyc;
    v        = vecs[i];
    bt[0]    = v.b0;
    bt[1]    = v.b1;
    bt[2]    = v.b2;
    bt[3]    = v.b3;
    exp_line = {v.b3, v.b2, v.b1, v.b0};
    hold_ok  = 1; busy_ok = 1; early_ok = 1; spur_ok = 1; ackr_ok = 1; line_ok = 1;

    bus.icache_req_addr       = v.addr;
    bus.icache_req_addr_valid = 1'b1;
    if (v.spur) begin
      bus.mem_ack_valid = 1'b1;
      bus.mem_ack_data  = 64'hDEAD;
      chk($sformatf("v%0d_idle_spur_ack_retry", i), bus.mem_ack_retry, 1);
    end
    chk($sformatf("v%0d_idle_accepts", i), bus.icache_req_addr_retry, 0);
    step();
    cyc = 1;
    if (v.chain) bus.icache_req_addr = vecs[i+1].addr;
    else         bus.icache_req_addr_valid = 1'b0;

    for (int k = 0; k <= v.req_retry; k++) begin
      if (!(bus.mem_req_valid === 1'b1 && bus.mem_req_addr === v.exp_addr)) hold_ok = 0;
      if (bus.icache_req_addr_retry !== 1'b1) busy_ok = 0;
      if (bus.icache_ack_data_valid !== 1'b0) early_ok = 0;
      if (v.spur && bus.mem_ack_retry !== 1'b1) spur_ok = 0;
      bus.mem_req_retry = (k < v.req_retry);
      step();
      cyc++;
    end
    bus.mem_req_retry = 1'b0;
    bus.mem_ack_valid = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (b == 1) begin
        for (int g = 0; g < v.gap; g++) begin
          bus.mem_ack_valid = 1'b0;
          if (bus.mem_ack_retry !== 1'b0) ackr_ok = 0;
          if (bus.icache_req_addr_retry !== 1'b1) busy_ok = 0;
          if (bus.icache_ack_data_valid !== 1'b0) early_ok = 0;
          step();
          cyc++;
        end
      end
      bus.mem_ack_valid = 1'b1;
      bus.mem_ack_data  = bt[b];
      if (bus.mem_ack_retry !== 1'b0) ackr_ok = 0;
      if (bus.icache_req_addr_retry !== 1'b1) busy_ok = 0;
      if (bus.icache_ack_data_valid !== 1'b0) early_ok = 0;
      step();
      cyc++;
    end
    bus.mem_ack_valid = 1'b0;
    bus.mem_ack_data  = '0;

    while (bus.icache_ack_data_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk($sformatf("v%0d_ack_latency", i), cyc, v.exp_lat);
    chk($sformatf("v%0d_line", i), bus.icache_ack_data, exp_line);

    for (int k = 0; k <= v.core_retry; k++) begin
      if (!(bus.icache_ack_data_valid === 1'b1 && bus.icache_ack_data === exp_line)) line_ok = 0;
      if (bus.icache_req_addr_retry !== 1'b1) busy_ok = 0;
      bus.icache_ack_data_retry = (k < v.core_retry);
      step();
    end
    bus.icache_ack_data_retry = 1'b0;

    chk($sformatf("v%0d_mem_req_stable", i), hold_ok,  1);
    chk($sformatf("v%0d_busy_retry", i),     busy_ok,  1);
    chk($sformatf("v%0d_no_early_ack", i),   early_ok, 1);
    chk($sformatf("v%0d_recv_ack_retry", i), ackr_ok,  1);
    chk($sformatf("v%0d_line_held", i),      line_ok,  1);
    if (v.spur) chk($sformatf("v%0d_req_spur_ack_retry", i), spur_ok, 1);
    chk($sformatf("v%0d_idle_ack_valid", i), bus.icache_ack_data_valid, 0);
    chk($sformatf("v%0d_idle_ack_retry", i), bus.mem_ack_retry, 1);
  endtask

  initial begin
    vecs[0] = '{addr: 64'h0000_0000_1000_0047, exp_addr: 64'h0000_0000_1000_0040,
                b0: 64'h1111_1111_1111_1111, b1: 64'h2222_2222_2222_2222,
                b2: 64'h3333_3333_3333_3333, b3: 64'h4444_4444_4444_4444,
                req_retry: 0, gap: 0, core_retry: 0, spur: 0, chain: 0, exp_lat: 6};
    vecs[1] = '{addr: 64'h0000_0000_ABCD_E01F, exp_addr: 64'h0000_0000_ABCD_E000,
                b0: 64'h0123_4567_89AB_CDEF, b1: 64'hFEDC_BA98_7654_3210,
                b2: 64'h5555_5555_5555_5555, b3: 64'hAAAA_AAAA_AAAA_AAAA,
                req_retry: 3, gap: 2, core_retry: 0, spur: 0, chain: 0, exp_lat: 11};
    vecs[2] = '{addr: 64'hFFFF_FFFF_FFFF_FFFF, exp_addr: 64'hFFFF_FFFF_FFFF_FFE0,
                b0: 64'h0000_0000_0000_0001, b1: 64'h0000_0000_0000_0002,
                b2: 64'h0000_0000_0000_0003, b3: 64'h8000_0000_0000_0000,
                req_retry: 0, gap: 0, core_retry: 4, spur: 0, chain: 0, exp_lat: 6};
    vecs[3] = '{addr: 64'h0000_0000_0000_0020, exp_addr: 64'h0000_0000_0000_0020,
                b0: 64'hC0DE_0000_0000_00A0, b1: 64'hC0DE_0000_0000_00A1,
                b2: 64'hC0DE_0000_0000_00A2, b3: 64'hC0DE_0000_0000_00A3,
                req_retry: 1, gap: 0, core_retry: 0, spur: 1, chain: 0, exp_lat: 7};
    vecs[4] = '{addr: 64'h0000_0000_4000_0010, exp_addr: 64'h0000_0000_4000_0000,
                b0: 64'h4040_0000_0000_0000, b1: 64'h4040_0000_0000_0001,
                b2: 64'h4040_0000_0000_0002, b3: 64'h4040_0000_0000_0003,
                req_retry: 0, gap: 0, core_retry: 2, spur: 0, chain: 1, exp_lat: 6};
    vecs[5] = '{addr: 64'h0000_0000_2000_0000, exp_addr: 64'h0000_0000_2000_0000,
                b0: 64'h2020_2020_0000_0000, b1: 64'h2020_2020_1111_1111,
                b2: 64'h2020_2020_2222_2222, b3: 64'h2020_2020_3333_3333,
                req_retry: 0, gap: 1, core_retry: 0, spur: 0, chain: 0, exp_lat: 7};
    vecs[6] = '{addr: 64'h0000_0000_3000_00FF, exp_addr: 64'h0000_0000_3000_00E0,
                b0: 64'h7777_0000_0000_0007, b1: 64'h6666_0000_0000_0006,
                b2: 64'h5555_0000_0000_0005, b3: 64'h4444_0000_0000_0004,
                req_retry: 0, gap: 0, core_retry: 0, spur: 0, chain: 0, exp_lat: 6};

    reset                     = 1'b0;
    bus.icache_req_addr       = '0;
    bus.icache_req_addr_valid = 1'b0;
    bus.icache_ack_data_retry = 1'b0;
    bus.mem_req_retry         = 1'b0;
    bus.mem_ack_data          = '0;
    bus.mem_ack_valid         = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_fill(i);

    // Abort a fill after two beats; reset must clear outputs without a clock edge.
    bus.icache_req_addr       = 64'h0000_0000_5000_0000;
    bus.icache_req_addr_valid = 1'b1;
    step();
    bus.icache_req_addr_valid = 1'b0;
    step();
    bus.mem_ack_valid = 1'b1;
    bus.mem_ack_data  = 64'h9999_9999_9999_9999;
    step();
    bus.mem_ack_data  = 64'h8888_8888_8888_8888;
    step();
    bus.mem_ack_valid = 1'b0;
    bus.mem_ack_data  = '0;
    chk("midfill_in_recv", bus.mem_ack_retry, 0);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    reset = 1'b1;
    @(negedge clk);

    do_fill(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Instruction-line fill engine sitting directly downstream of the core's fetch request port. It accepts one 32-byte-aligned line request from the core and issues a single burst read to a 64-bit memory port. It assembles the four returned beats into a 256-bit line and hands it back on the core's icache ack port. There is one outstanding line at a time, and valid/retry handshakes are used on all four channels.

## Interface
- `BEAT_W`, default 64: memory data beat width in bits.
- `BEATS`, default 4: beats per line. Line width = `BEAT_W*BEATS` = 256.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `icache_req_addr`  in  64  fetch address from core; bits [4:0] ignored.
- `icache_req_addr_valid`  in  1  core request valid.
- `icache_req_addr_retry`  out  1  engine busy; request not accepted.
- `icache_ack_data`  out  256  assembled line; beat i occupies [64i+63:64i].
- `icache_ack_data_valid`  out  1  line valid to core.
- `icache_ack_data_retry`  in  1  core cannot accept the line this cycle.
- `mem_req_addr`  out  64  line address, `{req_addr[63:5],5'b0}`.
- `mem_req_valid`  out  1  burst read request valid.
- `mem_req_retry`  in  1  memory cannot accept the request.
- `mem_ack_data`  in  64  returned beat.
- `mem_ack_valid`  in  1  beat valid.
- `mem_ack_retry`  out  1  engine not accepting beats.

## Operation
- **Handshake rule (all channels):** a transfer occurs on a rising edge where valid=1 and retry=0. The sender holds valid and payload stable until the transfer occurs.
- **FSM states:** IDLE, REQ, RECV, RESP.
- **IDLE**
  - `icache_req_addr_retry`=0, `mem_ack_retry`=1, other valids 0.
  - When `icache_req_addr_valid`=1: latch `{addr[63:5],5'b0}` into `line_addr`, then go to REQ.
- **REQ**
  - `mem_req_valid`=1, `mem_req_addr`=`line_addr`.
  - When `mem_req_retry`=0: clear beat counter to 0, then go to RECV.
  - While `mem_req_retry`=1: stay in REQ.
- **RECV**
  - `mem_ack_retry`=0.
  - Each `mem_ack_valid` beat: write `mem_ack_data` into line slot `beat`, then increment `beat` (2-bit counter).
  - Beat accepted with `beat`==`BEATS-1`: go to RESP.
  - Cycles without `mem_ack_valid` (gaps) are allowed and hold state.
- **RESP**
  - `icache_ack_data_valid`=1 with the full line.
  - When `icache_ack_data_retry`=0: go to IDLE.
  - While retry=1: hold the line unchanged.
- `icache_req_addr_retry`=1 in every state except IDLE. A new request can therefore be accepted no earlier than the cycle after the line transfer.
- `mem_ack_valid` outside RECV is ignored: no state or data change, and `mem_ack_retry` stays 1.
- `mem_ack_data` is consumed only in RECV. Beat order is fixed: the first beat received goes to bits [63:0].
- The line buffer is not cleared between fills. Every slot is overwritten before RESP, so no stale data is ever presented.

## Timing
- **Reset:** while `reset`=0, state=IDLE, `beat`=0, `line_addr`=0 and line buffer=0. Output values during reset:
  - `icache_req_addr_retry`=0
  - `icache_ack_data_valid`=0
  - `icache_ack_data`=0
  - `mem_req_valid`=0
  - `mem_req_addr`=0
  - `mem_ack_retry`=1
- Reset asserted mid-fill aborts the fill immediately and asynchronously; partial beats are discarded. After deassertion the first accepted request starts a fresh fill.
- All outputs are registered-state decodes; none depends combinationally on `mem_ack_valid`, `mem_req_retry` or `icache_ack_data_retry`.
- **Minimum latency, no retries.** Request accepted at edge T; `mem_req_valid` high in cycle T+1 and accepted at the end of T+1. Beats arrive in cycles T+2..T+5. `icache_ack_data_valid` is high from cycle T+6.
- A memory beat presented in the same cycle the request is accepted is not taken (`mem_ack_retry`=1 in REQ).
- The core's request may be presented in the same cycle the engine returns to IDLE. It is accepted at that edge.

## Test plan
- **Basic fill.** After reset, request `0x1000_0047`, memory with zero retries returning beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44`. Expected:
  - `mem_req_addr`=`0x1000_0040`
  - ack valid 6 cycles after request accept
  - `icache_ack_data`={`0x44..44`,`0x33..33`,`0x22..22`,`0x11..11`}
- **Memory backpressure.** `mem_req_retry`=1 for 3 cycles, plus 2 idle gaps between beats 1 and 2. Expected: `mem_req_valid` and `mem_req_addr` held stable throughout; line still correct; ack valid at 6+3+2=11 cycles.
- **Core backpressure.** `icache_ack_data_retry`=1 for 4 cycles in RESP. Expected: line held constant; `icache_req_addr_retry` stays 1; return to IDLE on the first cycle with retry=0.
- **Back-to-back fills.** Second request (`0x2000_0000`) is held valid during the first fill. Expected: it is accepted exactly on the edge after the first line transfers; its memory request carries `0x2000_0000`.
- **Spurious beat.** `mem_ack_valid`=1 with data `0xDEAD` while in IDLE and REQ. Expected: ignored; `mem_ack_retry`=1; the next fill contains no `0xDEAD`.
- **Mid-fill reset.** Pull `reset` low after beat 2 of a fill. Expected: all outputs take their reset values immediately; after release, a fresh request fills correctly with all 4 new beats.
